mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers for the nanoMIPS core.
- Sits in the execute stage beside the ALU.
- Its hi/lo outputs feed the write-back select mux, which picks among ALU result, memory data and HI/LO for MFHI/MFLO.
- The core stalls PC advance while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO register width
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  operation code, from the mdu_pkg encoding
- a  input  WIDTH  rs operand: multiplicand or dividend, and MTHI/MTLO data
- b  input  WIDTH  rt operand: multiplier or divisor
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO are updated by MULT*/DIV*
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On the reset edge: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
  - Reset during RUN or FINISH aborts the operation; no partial result reaches HI/LO.
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5. Codes 6 and 7 are NOP: ignored, no state change.
- State machine: IDLE -> RUN -> FINISH -> IDLE.
- IDLE:
  - start=1 with MTHI: hi<=a on the same edge. No busy, no done.
  - start=1 with MTLO: lo<=a on the same edge. No busy, no done.
  - start=1 with MULT*/DIV*:
    - latch operands; signed ops latch |a| and |b| and record the result signs;
    - counter<=0, state<=RUN.
    - busy is 1 in the following cycle.
- RUN: one iteration per clock, exactly WIDTH iterations.
  - Multiply: shift-add over the 2*WIDTH product register.
  - Divide: restoring division, one quotient bit per cycle.
  - When counter reaches WIDTH-1 the state goes to FINISH.
- FINISH: lasts one cycle.
  - Apply sign correction: negative quotient if operand signs differ; remainder takes the dividend's sign; negate the product if the signs differ.
  - On the exit edge: hi/lo written, done<=1 for exactly one cycle, state<=IDLE.
- Result mapping: MULT* gives hi=product[2W-1:W], lo=product[W-1:0]. DIV* gives lo=quotient, hi=remainder.
- Latency: start sampled at edge k; busy=1 after edges k through k+33; hi/lo new values and done=1 in the cycle after edge k+33, i.e. 33 cycles after start.
- start while busy=1 is ignored, including MTHI/MTLO. The core guarantees it holds the instruction, and the unit does not queue.
- Divide by zero: no exception. Result is lo=all ones, hi=a (the original signed a). Still takes the full 33 cycles.
- DIV overflow, 0x80000000 / -1: lo=0x80000000, hi=0 (two's-complement wrap).
- hi/lo are stable except on the update edges listed above; MFHI/MFLO may read them combinationally at any time.
- a and b may change after the start edge without affecting the result.

Decomposition:
- Shared package mdu_pkg holds:
  - op code localparams (MDU_MULT … MDU_MTLO);
  - state encoding (S_IDLE, S_RUN, S_FINISH);
  - the WIDTH default.
- One natural sub-module: mdu_step, purely combinational.
  - Inputs: mode, partial remainder/product, operand.
  - Outputs: the next partial value and the quotient bit.
  - Keeps the iteration datapath separate from the FSM and the sign handling.

Test Plan:
- Reset then idle: reset held 2 cycles -> hi=0, lo=0, busy=0, done=0. start with op=6 -> no change.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy asserted for 34 cycles; done pulse at cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42). DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 -> hi updated the next cycle, busy stays 0. Then start MULTU 3*5, and mid-run issue MTLO 0xDEAD plus a second start -> both ignored; final hi=0, lo=15.
- Start DIVU 1000/7, assert reset at cycle 10 -> busy=0, hi=lo=0 the next cycle, no done pulse. A fresh DIVU 1000/7 afterwards -> lo=142, hi=6.

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes,
// FSM state encoding and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_hilo_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-division step on the 2*WIDTH accumulator.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               qbit
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] trial_s;

  // Multiply keeps the carry in the top bit before shifting right; divide
  // trials a subtract on the shifted remainder, borrow means quotient bit 0.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
    trial_s  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    qbit     = 1'b0;
    acc_next = acc;
    if (is_div) begin
      qbit = ~trial_s[WIDTH];
      if (qbit) begin
        acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Operands are reduced to magnitudes up front; signs are restored in FINISH.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_r, state_n;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opd_r;
  logic [WIDTH-1:0]   a_orig_r;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic               bzero_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               accept_s;
  logic               muldiv_s;
  logic               signed_s;
  logic [2*WIDTH-1:0] step_next_s;
  logic               step_q_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  assign accept_s = start && (state_r == S_IDLE) && !busy_r;
  assign muldiv_s = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  assign signed_s = (op == MDU_MULT) || (op == MDU_DIV);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_r),
    .acc      (acc_r),
    .opd      (opd_r),
    .acc_next (step_next_s),
    .qbit     (step_q_s)
  );

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && muldiv_s) begin
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_n = S_FINISH;
        end else begin
          state_n = S_RUN;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Sign restoration and HI/LO mapping of the finished accumulator
  always_comb begin
    prod_s   = neg_res_r ? (~acc_r + (2*WIDTH)'(1)) : acc_r;
    quo_s    = neg_res_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
    rem_s    = neg_rem_r ? (~acc_r[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_r[2*WIDTH-1:WIDTH];
    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      if (bzero_r) begin
        res_hi_s = a_orig_r;
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_hi_s = rem_s;
        res_lo_s = quo_s;
      end
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // State register, operand latch, iteration and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      acc_r     <= '0;
      opd_r     <= '0;
      a_orig_r  <= '0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      bzero_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      state_r <= state_n;
      done_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            case (op)
              MDU_MTHI: hi_r <= a;
              MDU_MTLO: lo_r <= a;
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                is_div_r  <= op[1];
                neg_res_r <= signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_r <= signed_s && a[WIDTH-1];
                bzero_r   <= (b == '0);
                a_orig_r  <= a;
                cnt_r     <= '0;
                busy_r    <= 1'b1;
                // Multiply shifts the multiplier out of the low half; divide
                // shifts the dividend out of the low half into the remainder.
                if (op[1]) begin
                  acc_r <= {{WIDTH{1'b0}}, mag(a, signed_s)};
                  opd_r <= mag(b, signed_s);
                end else begin
                  acc_r <= {{WIDTH{1'b0}}, mag(b, signed_s)};
                  opd_r <= mag(a, signed_s);
                end
              end
              default: ;
            endcase
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_RUN: begin
          acc_r <= step_next_s | {{(2*WIDTH-1){1'b0}}, step_q_s};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        S_FINISH: begin
          hi_r   <= res_hi_s;
          lo_r   <= res_lo_s;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI/LO pushed at issue, checked by
// a monitor on every done pulse against a plain-arithmetic reference.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint p, q, r;
    longint unsigned pu;
    e.due = 0;
    e.hi = 32'd0;
    e.lo = 32'd0;
    case (o)
      MDU_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MDU_MULTU: begin
        pu = {32'd0, x} * {32'd0, y};
        e.hi = pu[63:32]; e.lo = pu[31:0];
      end
      MDU_DIV: begin
        if (y == 32'd0) begin
          e.hi = x; e.lo = 32'hFFFF_FFFF;
        end else begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          e.hi = r[31:0]; e.lo = q[31:0];
        end
      end
      default: begin
        if (y == 32'd0) begin
          e.hi = x; e.lo = 32'hFFFF_FFFF;
        end else begin
          e.hi = x % y; e.lo = x / y;
        end
      end
    endcase
    return e;
  endfunction

  // Called right after a negedge; returns once the request edge has passed.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    if (o <= MDU_DIVU) begin
      e = model(o, x, y);
      e.due = cyc + 33;
      sb.push_back(e);
    end else if (o == MDU_MTHI) begin
      cur_hi = x;
    end else if (o == MDU_MTLO) begin
      cur_lo = x;
    end
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation and its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("res_hi", hi, e.hi);
        check("res_lo", lo, e.lo);
        check("latency", 32'(cyc), 32'(e.due));
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end
  end

  initial begin
    int nb;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    issue(3'd6, 32'hCAFE_F00D, 32'h1);
    check("nop_hi", hi, 32'd0);
    check("nop_lo", lo, 32'd0);
    check("nop_busy", 32'(busy), 32'd0);

    // MULTU max: count busy cycles
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    nb = 1;
    while (busy === 1'b1 && nb < 100) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    check("busy_cycles", 32'(nb), 32'd34);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    issue(MDU_MULT, 32'hFFFF_FFF9, 32'd6);   wait_idle();
    check("mult_lo", lo, 32'hFFFF_FFD6);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);    wait_idle();
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(MDU_DIVU, 32'd100, 32'd0);         wait_idle();
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'd100);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd0);    wait_idle();

    issue(MDU_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", 32'(busy), 32'd0);

    // Requests during RUN must be dropped
    issue(MDU_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MTLO; a = 32'h0000_DEAD;
    @(negedge clk);
    op = MDU_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("midrun_lo", lo, cur_lo);
    check("midrun_hi", hi, 32'h1234_5678);
    wait_idle();
    check("mul35_hi", hi, 32'd0);
    check("mul35_lo", lo, 32'd15);

    // Reset mid-operation aborts without a done pulse
    issue(MDU_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    cur_hi = 32'd0; cur_lo = 32'd0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    issue(MDU_DIVU, 32'd1000, 32'd7);        wait_idle();
    check("div7_lo", lo, 32'd142);
    check("div7_hi", hi, 32'd6);

    // Randomized mix, including MT ops and zero/small divisors
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) ra = 32'($signed(-$urandom_range(1, 5000)));
      issue(ro, ra, rb);
      wait_idle();
      check("rand_hi", hi, cur_hi);
      check("rand_lo", lo, cur_lo);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
